blackjack_hand_rx: RTL

// - Consumer side of the card-request interface. Issues request_card_o to the random card source and samples the returned 8-bit card.
// - Accumulates one blackjack hand: running total, soft ace, bust and blackjack flags.
// - Sits between player controls (hit/stand/new round) and the card source; one instance per player or dealer seat.

---
 rtl/blackjack_hand_rx_pkg.sv | 25 ++
 rtl/blackjack_hand_rx_hand_value_calc.sv | 38 +++
 rtl/blackjack_hand_rx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/blackjack_hand_rx_pkg.sv
// Shared constants, card field positions and FSM state encoding for the blackjack hand receiver.
// Optional build macro used by the top: DEALER_AUTOPLAY_EN.
package blackjack_hand_rx_pkg;

    localparam int RANK_LSB = 0;
    localparam int RANK_MSB = 3;
    localparam int SUIT_LSB = 4;
    localparam int SUIT_MSB = 5;

    localparam logic [3:0] RANK_ACE  = 4'd1;
    localparam logic [3:0] RANK_KING = 4'd13;

    localparam logic [4:0] BJ_LIMIT     = 5'd21;
    localparam logic [4:0] DEALER_STAND = 5'd17;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        ACCUM  = 3'd3,
        PLAYER = 3'd4,
        DONE   = 3'd5
    } state_e;

endpackage

// File: rtl/blackjack_hand_rx_hand_value_calc.sv
// Combinational card valuation (rank -> value, ace, validity) and best-hand evaluation
// (hard sum plus ace -> total with soft-ace promotion, saturated at 31).
module hand_value_calc
    import blackjack_hand_rx_pkg::*;
(
    input  logic [3:0] rank_i,
    input  logic [5:0] hard_sum_i,
    input  logic       ace_i,
    output logic       card_valid_o,
    output logic       card_ace_o,
    output logic [3:0] card_value_o,
    output logic [4:0] hand_total_o,
    output logic       soft_o
);

    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        card_valid_o = (rank_i >= RANK_ACE) && (rank_i <= RANK_KING);
        card_ace_o   = (rank_i == RANK_ACE);
        if (!card_valid_o) begin
            card_value_o = 4'd0;
        end else if (rank_i > 4'd10) begin
            card_value_o = 4'd10;
        end else begin
            card_value_o = rank_i;
        end

        soft_o = ace_i && (hard_sum_i <= 6'd11);
        if (soft_o) begin
            hand_total_o = hard_sum_i[4:0] + 5'd10;
        end else if (hard_sum_i > 6'd31) begin
            hand_total_o = 5'd31;
        end else begin
            hand_total_o = hard_sum_i[4:0];
        end
    end

endmodule

// File: rtl/blackjack_hand_rx.sv
// One blackjack hand: requests cards, waits CARD_LATENCY cycles, validates and accumulates them.
// Define DEALER_AUTOPLAY_EN to replace hit/stand control with the dealer hit-below-17 rule.
module blackjack_hand_rx
    import blackjack_hand_rx_pkg::*;
#(
    parameter int CARD_LATENCY = 1,
    parameter int MAX_CARDS    = 11,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       new_round_i,
    input  logic       hit_i,
    input  logic       stand_i,
    input  logic [7:0] card_i,
    output logic       request_card_o,
    output logic [4:0] hand_total_o,
    output logic [3:0] card_count_o,
    output logic       soft_o,
    output logic       bust_o,
    output logic       blackjack_o,
    output logic       done_o,
    output logic       error_o
);

    localparam logic [3:0] LATENCY_W   = 4'(CARD_LATENCY);
    localparam logic [3:0] MAX_CARDS_W = 4'(MAX_CARDS);
    localparam logic [3:0] MAX_RETRY_W = 4'(MAX_RETRY);

    state_e     state_q;
    logic [3:0] wait_q;
    logic [3:0] rank_q;
    logic [5:0] hard_sum_q;
    logic       ace_q;
    logic [3:0] count_q;
    logic [3:0] retry_q;
    logic [4:0] total_q;
    logic       soft_q;
    logic       bust_q;
    logic       bj_q;
    logic       done_q;
    logic       error_q;
    logic       req_q;
    logic       hit_prev_q;

    logic       card_valid;
    logic       card_ace;
    logic [3:0] card_value;
    logic [5:0] sum_d;
    logic       ace_d;
    logic [3:0] count_d;
    logic [4:0] total_d;
    logic       soft_d;
    logic       hit_rise;

    // Candidate hand if the card held in rank_q is accepted this cycle.
    assign sum_d    = hard_sum_q + {2'b00, card_value};
    assign ace_d    = ace_q | card_ace;
    assign count_d  = count_q + 4'd1;
    assign hit_rise = hit_i & ~hit_prev_q;

    hand_value_calc u_calc (
        .rank_i       (rank_q),
        .hard_sum_i   (sum_d),
        .ace_i        (ace_d),
        .card_valid_o (card_valid),
        .card_ace_o   (card_ace),
        .card_value_o (card_value),
        .hand_total_o (total_d),
        .soft_o       (soft_d)
    );

    logic unused_inputs;
`ifdef DEALER_AUTOPLAY_EN
    assign unused_inputs = ^{card_i[7:RANK_MSB+1], hit_rise, stand_i};
`else
    assign unused_inputs = ^card_i[7:RANK_MSB+1];
`endif

    // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            wait_q     <= 4'd0;
            rank_q     <= 4'd0;
            hard_sum_q <= 6'd0;
            ace_q      <= 1'b0;
            count_q    <= 4'd0;
            retry_q    <= 4'd0;
            total_q    <= 5'd0;
            soft_q     <= 1'b0;
            bust_q     <= 1'b0;
            bj_q       <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            req_q      <= 1'b0;
            hit_prev_q <= 1'b0;
        end else begin
            hit_prev_q <= hit_i;
            req_q      <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (new_round_i) begin
                        hard_sum_q <= 6'd0;
                        ace_q      <= 1'b0;
                        count_q    <= 4'd0;
                        retry_q    <= 4'd0;
                        total_q    <= 5'd0;
                        soft_q     <= 1'b0;
                        bust_q     <= 1'b0;
                        bj_q       <= 1'b0;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        req_q      <= 1'b1;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    wait_q  <= LATENCY_W;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // The count reaches zero on the CARD_LATENCY-th cycle after the request.
                    wait_q <= wait_q - 4'd1;
                    if (wait_q <= 4'd1) begin
                        rank_q  <= card_i[RANK_MSB:RANK_LSB];
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (!card_valid) begin
                        if (retry_q < MAX_RETRY_W) begin
                            retry_q <= retry_q + 4'd1;
                            req_q   <= 1'b1;
                            state_q <= REQ;
                        end else begin
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end else begin
                        retry_q    <= 4'd0;
                        hard_sum_q <= sum_d;
                        ace_q      <= ace_d;
                        count_q    <= count_d;
                        total_q    <= total_d;
                        soft_q     <= soft_d;
                        if (count_d < 4'd2) begin
                            req_q   <= 1'b1;
                            state_q <= REQ;
                        end else if (count_d == 4'd2 && total_d == BJ_LIMIT) begin
                            bj_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (total_d > BJ_LIMIT) begin
                            bust_q  <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (count_d == MAX_CARDS_W) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= PLAYER;
                        end
                    end
                end
                PLAYER: begin
`ifdef DEALER_AUTOPLAY_EN
                    if (total_q >= DEALER_STAND) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
`else
                    if (stand_i) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (hit_rise) begin
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign request_card_o = req_q;
    assign hand_total_o   = total_q;
    assign card_count_o   = count_q;
    assign soft_o         = soft_q;
    assign bust_o         = bust_q;
    assign blackjack_o    = bj_q;
    assign done_o         = done_q;
    assign error_o        = error_q;

endmodule
